// File: rtl/router_fifo.sv
// router_fifo: per-port packet FIFO for the router.
// Each entry stores a payload byte plus a header marker bit. Reading a header
// entry loads a packet byte counter so pkt_active tracks bytes still owed to
// the destination client (payload plus trailing parity byte).
// Optional feature: define ROUTER_FIFO_OVERFLOW_ERR_EN to add a sticky
// overflow_err output, set whenever a write arrives while the FIFO is full.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
`ifdef ROUTER_FIFO_OVERFLOW_ERR_EN
  output logic             overflow_err,
`endif
  output logic             pkt_active
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = 7;

  // Entry layout: bit WIDTH is the header marker, bits WIDTH-1:0 the byte.
  logic [WIDTH:0]   mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;

  logic             wr_fire;
  logic             rd_fire;
  logic [WIDTH:0]   rd_entry;
  logic [CW-1:0]    hdr_cnt;

  // Pointer compare: equal pointers mean empty; same address with opposite
  // wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Full and empty are taken from the pre-edge pointers, so a simultaneous
  // read on full or write on empty only lets the legal side through.
  assign wr_fire  = write_enb && !full;
  assign rd_fire  = read_enb && !empty;
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  // Header byte bits 7:2 carry the payload length; +1 accounts for parity.
  assign hdr_cnt = CW'(rd_entry[WIDTH-1:2]) + CW'(1);

  assign data_out   = data_out_q;
  assign pkt_active = (pkt_cnt_q != '0);

  // Next-state for pointers, read data and packet counter; soft_reset flushes
  // everything and wins over any read or write in the same cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      data_out_d = '0;
      pkt_cnt_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_fire) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        data_out_d = rd_entry[WIDTH-1:0];
        if (rd_entry[WIDTH]) begin
          // A new header always restarts the count, even mid-packet.
          pkt_cnt_d = hdr_cnt;
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d = pkt_cnt_q - CW'(1);
        end
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Storage array; contents survive reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst && !soft_reset && wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

`ifdef ROUTER_FIFO_OVERFLOW_ERR_EN
  logic overflow_err_q;

  assign overflow_err = overflow_err_q;

  // Sticky flag for writes dropped on full; only the hard reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_err_q <= 1'b0;
    end else if (write_enb && full) begin
      overflow_err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: packet counting, full/empty boundaries,
// simultaneous access corner cases, soft flush and pointer wrap.
module tb_router_fifo;

  logic       clk;
  logic       rst;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_active;
`ifdef ROUTER_FIFO_OVERFLOW_ERR_EN
  logic       overflow_err;
`endif

  int n_checks;
  int n_fail;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
`ifdef ROUTER_FIFO_OVERFLOW_ERR_EN
    .overflow_err (overflow_err),
`endif
    .pkt_active (pkt_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    soft_reset = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic do_write(input logic [7:0] d, input logic hdr);
    idle();
    write_enb = 1'b1;
    lfd_state = hdr;
    data_in   = d;
    tick();
    idle();
  endtask

  task automatic do_read();
    idle();
    read_enb = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || pkt_active !== 1'b0 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: empty=%b full=%b pkt_active=%b data_out=%h, need 1 0 0 00",
               empty, full, pkt_active, data_out);
    end
`ifdef ROUTER_FIFO_OVERFLOW_ERR_EN
    n_checks++;
    if (overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: overflow_err=%b, need 0", overflow_err);
    end
`endif
  endtask

  task automatic test_packet();
    logic [7:0] exp_d [5];
    logic       exp_a [5];
    exp_d[0] = 8'h0D; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2; exp_d[3] = 8'hA3; exp_d[4] = 8'h55;
    exp_a[0] = 1'b1;  exp_a[1] = 1'b1;  exp_a[2] = 1'b1;  exp_a[3] = 1'b1;  exp_a[4] = 1'b0;
    do_write(8'h0D, 1'b1);
    n_checks++;
    if (empty !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_empty_fall: empty=%b, need 0", empty);
    end
    for (int i = 1; i < 5; i++) do_write(exp_d[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_read();
      n_checks++;
      if (data_out !== exp_d[i] || pkt_active !== exp_a[i]) begin
        n_fail++;
        $display("FAIL pkt_read%0d: data_out=%h pkt_active=%b, need %h %b",
                 i, data_out, pkt_active, exp_d[i], exp_a[i]);
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL pkt_end_empty: empty=%b, need 1", empty);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      do_write(8'h10 + 8'(i), 1'b0);
      if (i == 14) begin
        n_checks++;
        if (full !== 1'b0) begin
          n_fail++;
          $display("FAIL full_at15: full=%b, need 0", full);
        end
      end
    end
    n_checks++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_at16: full=%b, need 1", full);
    end
    do_write(8'hFF, 1'b0);
    n_checks++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drop: full=%b, need 1", full);
    end
`ifdef ROUTER_FIFO_OVERFLOW_ERR_EN
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ovf: overflow_err=%b, need 1", overflow_err);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      do_read();
      n_checks++;
      if (data_out !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL full_read%0d: data_out=%h, need %h", i, data_out, 8'h10 + 8'(i));
      end
    end
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: empty=%b full=%b, need 1 0", empty, full);
    end
  endtask

  task automatic test_rw_full();
    for (int i = 0; i < 16; i++) do_write(8'h20 + 8'(i), 1'b0);
    idle();
    read_enb  = 1'b1;
    write_enb = 1'b1;
    data_in   = 8'h77;
    tick();
    idle();
    n_checks++;
    if (data_out !== 8'h20 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_full: data_out=%h full=%b, need 20 0", data_out, full);
    end
`ifdef ROUTER_FIFO_OVERFLOW_ERR_EN
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_full_ovf: overflow_err=%b, need 1", overflow_err);
    end
`endif
    for (int i = 1; i < 16; i++) begin
      do_read();
      n_checks++;
      if (data_out !== 8'h20 + 8'(i)) begin
        n_fail++;
        $display("FAIL rw_full_read%0d: data_out=%h, need %h", i, data_out, 8'h20 + 8'(i));
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_full_drain: empty=%b, need 1", empty);
    end
  endtask

  task automatic test_rw_empty();
    idle();
    read_enb  = 1'b1;
    write_enb = 1'b1;
    data_in   = 8'h3C;
    tick();
    idle();
    n_checks++;
    if (data_out !== 8'h2F || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_empty: data_out=%h empty=%b, need 2f 0", data_out, empty);
    end
    do_read();
    n_checks++;
    if (data_out !== 8'h3C || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_empty_read: data_out=%h empty=%b, need 3c 1", data_out, empty);
    end
    do_read();
    n_checks++;
    if (data_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_on_empty_hold: data_out=%h, need 3c", data_out);
    end
  endtask

  task automatic test_header_reload();
    do_write(8'h0D, 1'b1);
    do_write(8'h00, 1'b1);
    do_write(8'hB0, 1'b0);
    do_read();
    do_read();
    n_checks++;
    if (pkt_active !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_hdr: pkt_active=%b, need 1", pkt_active);
    end
    do_read();
    n_checks++;
    if (pkt_active !== 1'b0 || data_out !== 8'hB0) begin
      n_fail++;
      $display("FAIL reload_end: pkt_active=%b data_out=%h, need 0 b0", pkt_active, data_out);
    end
  endtask

  task automatic test_soft_reset();
    do_write(8'h40, 1'b1);
    for (int i = 1; i < 10; i++) do_write(8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) do_read();
    n_checks++;
    if (pkt_active !== 1'b1 || data_out !== 8'h43) begin
      n_fail++;
      $display("FAIL soft_pre: pkt_active=%b data_out=%h, need 1 43", pkt_active, data_out);
    end
    idle();
    soft_reset = 1'b1;
    write_enb  = 1'b1;
    data_in    = 8'h99;
    tick();
    idle();
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00 || pkt_active !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_reset: empty=%b full=%b data_out=%h pkt_active=%b, need 1 0 00 0",
               empty, full, data_out, pkt_active);
    end
    do_read();
    n_checks++;
    if (empty !== 1'b1 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL soft_write_ignored: empty=%b data_out=%h, need 1 00", empty, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    do_write(8'h7F, 1'b0);
    for (int i = 0; i < 40; i++) begin
      idle();
      write_enb = 1'b1;
      read_enb  = 1'b1;
      data_in   = 8'h80 + 8'(i);
      tick();
      idle();
      exp = (i == 0) ? 8'h7F : 8'h80 + 8'(i - 1);
      n_checks++;
      if (data_out !== exp || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap%0d: data_out=%h empty=%b, need %h 0", i, data_out, empty, exp);
      end
    end
    do_read();
    n_checks++;
    if (data_out !== 8'hA7 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_last: data_out=%h empty=%b, need a7 1", data_out, empty);
    end
  endtask

  task automatic test_rst_priority();
    do_write(8'h11, 1'b1);
    do_read();
    idle();
    rst        = 1'b0;
    soft_reset = 1'b1;
    write_enb  = 1'b1;
    data_in    = 8'h22;
    tick();
    idle();
    rst = 1'b1;
    n_checks++;
    if (empty !== 1'b1 || data_out !== 8'h00 || pkt_active !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_priority: empty=%b data_out=%h pkt_active=%b, need 1 00 0",
               empty, data_out, pkt_active);
    end
`ifdef ROUTER_FIFO_OVERFLOW_ERR_EN
    n_checks++;
    if (overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ovf_clear: overflow_err=%b, need 0", overflow_err);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle();
    test_reset();
    test_packet();
    test_full();
    test_rw_full();
    test_rw_empty();
    test_header_reload();
    test_soft_reset();
    test_back_to_back();
    test_rst_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameters: DEPTH = 16, number of entries (power of two); WIDTH = 8, payload byte width.
REQ-002 clk  input  1  clock; all logic updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 soft_reset  input  1  per-port timeout flush, synchronous, active-high.
REQ-005 write_enb  input  1  write request, one bit of the synchronizer's write-enable vector.
REQ-006 read_enb  input  1  read request from the destination client.
REQ-007 lfd_state  input  1  high while data_in carries a packet header byte.
REQ-008 data_in  input  WIDTH  byte to store.
REQ-009 data_out  output  WIDTH  registered read data.
REQ-010 full  output  1  no free entry.
REQ-011 empty  output  1  no stored entry; drives valid_out = ~empty upstream.
REQ-012 pkt_active  output  1  high while bytes of the current packet remain to be read.

Function
REQ-013 Storage SHALL be DEPTH x (WIDTH+1) entries; bit WIDTH holds lfd_state as a header marker.
REQ-014 Pointers SHALL be log2(DEPTH)+1 bits: log2(DEPTH) address bits plus one wrap bit.
REQ-015 empty SHALL be 1 when the read and write pointers are fully equal; full SHALL be 1 when the address bits are equal and the wrap bits differ; both are combinational from the pointers.
REQ-016 Write: write_enb=1 and full=0 SHALL store {lfd_state, data_in} at the write address and increment the write pointer; a write while full SHALL be dropped with no state change.
REQ-017 Read: read_enb=1 and empty=0 SHALL load data_out with the stored byte (bits WIDTH-1:0) on that edge, giving 1-cycle latency, and increment the read pointer; a read while empty SHALL leave data_out and the pointers unchanged.
REQ-018 data_out SHALL hold its last value between reads.
REQ-019 Simultaneous read and write SHALL both take effect in the same cycle; full and empty are evaluated on pre-edge pointer values.
REQ-020 Read and write while full: the read proceeds and the write is dropped.
REQ-021 Read and write while empty: the write proceeds and the read is ignored.
REQ-022 Pointer increments SHALL wrap modulo 2*DEPTH.
REQ-023 Packet counter (7 bits):
  - on a read of a header entry, load stored payload length (byte bits 7:2) + 1, which covers the parity byte;
  - on a read of a non-header entry while the counter is nonzero, decrement by 1;
  - otherwise hold.
REQ-024 pkt_active SHALL be 1 exactly when the packet counter is nonzero.
REQ-025 A header read while the counter is nonzero SHALL reload the counter (new packet overrides the old one).

Reset
REQ-026 rst=0 SHALL clear both pointers, the packet counter and data_out to 0, and clear overflow_err if present; empty=1, full=0, pkt_active=0 thereafter.
REQ-027 rst SHALL take priority over soft_reset, read and write.
REQ-028 Memory contents SHALL NOT need to be cleared by reset.
REQ-029 soft_reset=1 SHALL apply the same clears as rst, except overflow_err, and SHALL override any read or write in the same cycle.
REQ-030 The flush SHALL apply even mid-packet.

Configuration
REQ-031 Macro ROUTER_FIFO_OVERFLOW_ERR_EN.
  - Defined: adds output overflow_err (1 bit), set sticky on any dropped write (write_enb=1 while full) and cleared only by rst.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 Reset then write header 0x0D (length 3, address 1) with lfd_state=1, then 0xA1, 0xA2, 0xA3, 0x55 -> empty falls the cycle after the first write; after 5 reads, data_out sequence is 0x0D, A1, A2, A3, 55 and pkt_active is 1 from the header read until the 5th read, then 0.
REQ-033 Write 16 bytes without reading -> full=1 after the 16th write; a 17th write of 0xFF is dropped; 16 reads return the original order; empty=1 at the end.
REQ-034 With 16 entries stored, assert read_enb and write_enb with 0x77 together -> read succeeds, write is dropped, full=0 afterwards, and overflow_err=1 when enabled.
REQ-035 From empty, assert read_enb and write_enb with 0x3C together -> data_out unchanged, empty=0 next cycle, next read returns 0x3C.
REQ-036 Store 10 entries, read 4, pulse soft_reset for 1 cycle with write_enb=1 -> empty=1, data_out=0, pkt_active=0, write ignored.
REQ-037 Run 40 write/read cycles -> data is intact across pointer wrap.
